// File: rtl/fetch_decode_queue.sv
// rtl/fetch_decode_queue.sv - fetch-to-decode instruction queue with single-cycle flush
module fetch_decode_queue #(
   parameter int          DEPTH    = 4,
   parameter int          PTR_W    = 2,
   parameter logic [31:0] NOP_WORD = 32'hD503201F
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   input  logic [31:0]      in_instruction,
   input  logic [63:0]      in_pc,
   output logic             in_ready,
   output logic             out_valid,
   output logic [31:0]      out_instruction,
   output logic [63:0]      out_pc,
   input  logic             out_ready,
   output logic [PTR_W:0]   count
);

   localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

   logic [95:0]      r_mem [DEPTH];
   logic [PTR_W-1:0] r_head;
   logic [PTR_W-1:0] r_tail;
   logic [PTR_W:0]   r_count;

   logic             w_enq;
   logic             w_deq;
   logic [95:0]      w_head_entry;

   // Handshake qualifiers; ready/valid come from registered count only,
   // so there is no combinational path from out_ready to in_ready.
   always_comb begin
      in_ready  = (r_count != FULL_CNT);
      out_valid = (r_count != '0);
      w_enq     = in_valid & in_ready & ~flush;
      w_deq     = out_valid & out_ready & ~flush;
   end

   // Head entry presented to decode, NOP/zero when nothing is buffered.
   always_comb begin
      w_head_entry    = r_mem[r_head];
      out_instruction = out_valid ? w_head_entry[31:0]  : NOP_WORD;
      out_pc          = out_valid ? w_head_entry[95:32] : 64'd0;
      count           = r_count;
   end

   // Entry storage; contents are don't-care until written, so no reset.
   always_ff @(posedge clock) begin
      if (w_enq) begin
         r_mem[r_tail] <= {in_pc, in_instruction};
      end
   end

   // Pointers and occupancy; flush wins over any enq/deq in the same cycle.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else if (flush) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (w_enq) begin
            r_tail <= r_tail + PTR_ONE;
         end
         if (w_deq) begin
            r_head <= r_head + PTR_ONE;
         end
         if (w_enq && !w_deq) begin
            r_count <= r_count + 1'b1;
         end else if (w_deq && !w_enq) begin
            r_count <= r_count - 1'b1;
         end
      end
   end

endmodule

// File: doc/fetch_decode_queue.md
# fetch_decode_queue

Instruction queue between the instruction-fetch stage and the decode stage of the pipelined ARMv8 core. It buffers up to DEPTH fetched {instruction, PC} pairs so that fetch can run ahead while decode is stalled. It presents the oldest entry to decode with a valid/ready handshake. A flush input, driven by the taken-branch signal, discards all buffered wrong-path instructions in one cycle.

## Interface
- DEPTH, 4: number of entries; power of two, at least 2.
- PTR_W, 2: pointer width, log2(DEPTH).
- NOP_WORD, 32'hD503201F: ARMv8 NOP encoding driven on out_instruction whenever out_valid is 0.

Ports:
- clock  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low; 0 clears all state immediately.
- flush  input  1  discard all entries (taken branch / redirect).
- in_valid  input  1  fetch presents an entry.
- in_instruction  input  32  fetched instruction word.
- in_pc  input  64  PC of the fetched instruction.
- in_ready  output  1  queue can accept an entry this cycle.
- out_valid  output  1  head entry is valid.
- out_instruction  output  32  head instruction; NOP_WORD when out_valid is 0.
- out_pc  output  64  head PC; 0 when out_valid is 0.
- out_ready  input  1  decode consumes the head this cycle.
- count  output  PTR_W+1  number of occupied entries, 0..DEPTH.

## Operation
- Storage is a circular buffer of DEPTH entries, each 96 bits ({pc, instruction}).
- Pointers:
  - head and tail are PTR_W-bit pointers and wrap from DEPTH-1 to 0.
  - count is tracked separately and never wraps.
- Conditions evaluated each cycle:
  - enq = in_valid & in_ready & ~flush.
  - deq = out_valid & out_ready & ~flush.
- enq writes {in_pc, in_instruction} at tail, then tail increments.
- deq increments head.
- count update:
  - +1 on enq only.
  - −1 on deq only.
  - Unchanged when both or neither occur.
- Output and ready logic:
  - in_ready = (count != DEPTH). It is derived from registered state only; there is no combinational path from out_ready.
  - out_valid = (count != 0).
  - out_instruction and out_pc are read from storage[head], muxed to NOP_WORD and 0 when empty.
- Flush:
  - Synchronous.
  - Next state: head = tail = 0, count = 0.
  - Flush takes priority over any enq or deq in the same cycle. The in_valid entry presented that cycle is dropped, and the head is not counted as consumed.
- Reset (reset = 0, asynchronous, any time including mid-operation):
  - head = tail = 0, count = 0.
  - out_valid = 0, out_instruction = NOP_WORD, out_pc = 0, in_ready = 1.
  - Storage contents need not be cleared.
- in_instruction and in_pc are sampled only when enq = 1. Decode must not assume the data is held stable otherwise.

## Timing
- Latency, empty queue: an entry enqueued at edge N appears with out_valid = 1 after edge N (visible cycle N+1). There is no same-cycle bypass.
- Throughput: one enq and one deq per cycle sustained when 0 < count < DEPTH.
- Full, count = DEPTH:
  - in_ready = 0 even if out_ready = 1 that cycle.
  - in_ready returns to 1 the cycle after a deq.
- Empty, count = 0: out_valid = 0; out_ready is ignored.
- Simultaneous enq and deq: count holds, and head and tail both advance.
- Wrap-around: after DEPTH enqueues, tail returns to 0. Ordering stays FIFO across the wrap.
- Flush at edge N: cycle N+1 has out_valid = 0, count = 0, in_ready = 1. A new enq is accepted at edge N+1.
- Reset release: the first edge with reset = 1 may enqueue.

## Test plan
- Reset and idle:
  - Stimulus: hold reset = 0, then release with in_valid = 0.
  - Required: out_valid = 0, out_instruction = 32'hD503201F, out_pc = 0, count = 0, in_ready = 1.
- Single pass:
  - Stimulus: enqueue {pc = 64'h1000, instr = 32'h8B020020} with out_ready = 1.
  - Required: the next cycle shows out_valid = 1 with those values. The following cycle is empty again.
- Fill and stall:
  - Stimulus: out_ready = 0; enqueue PCs 0x0, 0x4, 0x8, 0xC, then 0x10.
  - Required: count = 4 and in_ready = 0. The 0x10 entry is not accepted. Draining yields 0x0, 0x4, 0x8, 0xC in order.
- Wrap and streaming:
  - Stimulus: 10 consecutive enqueues (PC 0x0..0x24, step 4) with out_ready toggling 1,0,1,0,…
  - Required: all 10 entries emerge in order with none lost or duplicated, and count never exceeds 4.
- Flush priority:
  - Stimulus: with 3 entries queued, assert flush together with in_valid (PC 0x40) and out_ready = 1.
  - Required: the next cycle shows count = 0 and out_valid = 0. PC 0x40 never appears. An enqueue of PC 0x80 in the following cycle appears next.
- Async reset mid-stream:
  - Stimulus: pull reset low between edges while count = 2.
  - Required: outputs take their reset values immediately, without waiting for a clock edge.
